// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one tx_module UART transmitter between NUM_REQ byte producers.
// Optional SEND watchdog is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 tx_en_sig,
    output logic [7:0]           tx_data,
    input  logic                 tx_done_sig
);
    localparam int unsigned     ID_W     = 3;
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    win_id_c, idx_c;
    logic               win_found_c;
    logic               timeout_c;
    logic [7:0]         req_ext_c;
    logic [63:0]        data_ext_c;
    logic [7:0]         ack_onehot_c;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;

    // Absent requesters read as zero so the search can always use a 3-bit index.
    assign req_ext_c    = 8'(req);
    assign data_ext_c   = 64'(req_data);
    assign ack_onehot_c = 8'(1) << grant_q;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        idx_c       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_c = ID_W'((32'(last_q) + i) % NUM_REQ);
            if (!win_found_c && req_ext_c[idx_c]) begin
                win_found_c = 1'b1;
                win_id_c    = idx_c;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts SEND cycles; zero on the first SEND cycle.
    always_ff @(posedge sysclk) begin
        if (rst || (state_q != S_SEND)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == S_SEND) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_c      = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            grant_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    state_d = S_SEND;
                    last_d  = win_id_c;
                end
            end
            S_SEND: begin
                if (tx_done_sig || timeout_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered output values; a done pulse beats a coincident timeout.
    always_comb begin
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_d     = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                tx_en_d = 1'b0;
                if (win_found_c) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = data_ext_c[{win_id_c, 3'b000} +: 8];
                    grant_d   = win_id_c;
                end
            end
            S_SEND: begin
                if (state_d == S_DONE) begin
                    tx_en_d = 1'b0;
                    ack_d   = ack_onehot_c[NUM_REQ-1:0];
                    err_d   = timeout_c && !tx_done_sig;
                end
            end
            default: tx_en_d = 1'b0;
        endcase
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign tx_en_sig = tx_en_q;
    assign tx_data   = tx_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `tx_module` UART transmitter between up to eight byte producers. Each requester presents a byte with a level request. The arbiter grants one requester, then drives `tx_en_sig`/`tx_data` into `tx_module` and holds them until `tx_done_sig`. It returns a one-cycle acknowledge to the winner, then rotates priority. It sits between the application logic and `tx_module`, and the application never drives `tx_module` directly.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range 2..8.
- `TIMEOUT_CYCLES`, default 50000: watchdog limit in `sysclk` cycles. Used only when `UART_TX_ARB_TIMEOUT_EN` is defined.
- `sysclk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NUM_REQ: per-requester level request.
- `req_data` input 8*NUM_REQ: byte for requester i is `req_data[8i+7:8i]`.
- `ack` output NUM_REQ: one-hot, one-cycle pulse when the granted byte completes.
- `err` output 1: one-cycle pulse coincident with `ack` when the byte was aborted by the watchdog.
- `grant_id` output 3: index of the current or most recent grant.
- `busy` output 1: high whenever state is not IDLE.
- `tx_en_sig` output 1: to `tx_module.tx_en_sig`.
- `tx_data` output 8: to `tx_module.tx_data`.
- `tx_done_sig` input 1: from `tx_module.tx_done_sig`, a one-cycle pulse.

## Operation
- All outputs are registered.
- The FSM has four states: IDLE, SEND, DONE, GAP.
- IDLE behaviour:
  - If any `req` is high, pick the winner and latch its byte into `tx_data`.
  - Set `grant_id`, set `tx_en_sig`=1, and go to SEND.
  - If no `req` is high, stay in IDLE.
- Round-robin rule:
  - Pointer `last` holds the previous winner.
  - Search order is `last+1`, `last+2`, … modulo NUM_REQ. The first high `req` wins.
  - `last` updates to the winner on grant.
- SEND behaviour:
  - `tx_en_sig` and `tx_data` are held constant.
  - On `tx_done_sig`=1, go to DONE.
- DONE behaviour:
  - `tx_en_sig`=0 and `ack[grant_id]`=1 for exactly this cycle, then go to GAP.
- GAP behaviour:
  - One idle cycle, with `tx_en_sig` low, so the `tx_module` baud counter restarts.
  - Then go to IDLE.
- Requester contract:
  - `req_data` must be stable from `req` rise until arbitration.
  - Data is sampled only in IDLE. Changes after the grant are ignored.
  - To send one byte, drop `req` no later than the cycle after `ack`. A requester still high in IDLE is treated as a new request.
- `tx_done_sig` in any state other than SEND is ignored.
- Requesters with index ≥ NUM_REQ do not exist. `grant_id` upper bits are zero-extended.

## Timing
- Reset values take effect on the first edge with `rst`=1:
  - state IDLE, `last`=NUM_REQ-1 (so requester 0 has first priority), `grant_id`=0.
  - `tx_en_sig`=0, `tx_data`=0, `ack`=0, `err`=0, `busy`=0.
- Reset mid-SEND drops `tx_en_sig` on the next edge, which aborts `tx_module`. No `ack` is issued.
- Grant latency: with `req` high in IDLE on cycle k, `tx_en_sig`=1 and `busy`=1 on cycle k+1.
- Completion sequence:
  - `tx_done_sig` on cycle t gives DONE on t+1 (`ack`, `tx_en_sig`=0).
  - GAP follows on t+2 and IDLE on t+3.
  - The earliest next `tx_en_sig` is on t+4.
  - Minimum gap between grants is three cycles with `tx_en_sig` low.
- Simultaneous requests: exactly one grant per IDLE cycle, by round-robin order.
- A requester re-requesting continuously gets at most one grant per full rotation while others are pending.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to SEND and increments each SEND cycle.
  - When it reaches TIMEOUT_CYCLES without `tx_done_sig`, go to DONE with `err`=1 alongside `ack`.
  - If `tx_done_sig` and the timeout occur in the same cycle, done wins and `err`=0.
- Not defined:
  - No counter is built and `err` is tied to 0.
  - SEND waits indefinitely for `tx_done_sig`.

## Test plan
All scenarios use NUM_REQ=4. The bench `tx_done_sig` model pulses 20 cycles after `tx_en_sig` rises.
- Reset, then `req`=4'b0001 with data 0x55 held until `ack`:
  - `tx_en_sig` rises one cycle after IDLE sampling, with `tx_data`=0x55.
  - `ack`=4'b0001 one cycle after done, and `busy` drops three cycles after done.
- `req`=4'b1111 held with data 0x10/0x21/0x32/0x43:
  - Grants occur in order 0,1,2,3,0 and `tx_data` follows the same sequence.
  - Each pair of grants is separated by three cycles with `tx_en_sig` low.
- Requester 2 only, then requesters 1 and 3 together:
  - Grant goes to 3 first (search from 3), then 1.
- `rst` pulsed on the 10th SEND cycle:
  - Next cycle `tx_en_sig`=0, `ack`=0, `grant_id`=0.
  - The following request from requester 0 wins first.
- With `UART_TX_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, and `tx_done_sig` never pulsing:
  - `ack` and `err` pulse together on SEND cycle 9.
- With `UART_TX_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, and `tx_done_sig` on the timeout cycle:
  - `ack` is 1 and `err` is 0.
